// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says game sequencer.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHOW_ON,
    SHOW_OFF,
    INPUT,
    WIN,
    LOSE
  } state_t;

  typedef logic [3:0]  idx_t;
  typedef logic [15:0] pad_t;

  // Pad index to the single-bit button/LED pattern it stands for.
  function automatic pad_t onehot(idx_t i);
    return pad_t'(1) << i;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/simon_if.sv
// Game I/O bundle: player/LFSR inputs toward the sequencer, display and status back out.
// Latency: none (wiring only).
// Backpressure: none; every signal is a level or a one-cycle strobe.
interface simon_if
  import simon_pkg::*;
#(
  parameter int LW = 5
) ();

  logic          start;
  idx_t          rnd;
  pad_t          btn;
  idx_t          idx_out;
  logic          idx_en;
  logic [LW-1:0] level;
  logic          busy;
  logic          win;
  logic          lose;

  // Player, LFSR and display side.
  modport master (
    output start, rnd, btn,
    input  idx_out, idx_en, level, busy, win, lose
  );

  // Sequencer side.
  modport slave (
    input  start, rnd, btn,
    output idx_out, idx_en, level, busy, win, lose
  );

endinterface

// File: rtl/simon_dwell.sv
// Loadable down-counter timing how long the sequencer stays in a dwell state.
// Latency: done asserts load_val-1 cycles after the load edge (state lasts load_val cycles).
// Backpressure: none; a load always wins over counting, the count parks at zero.
module simon_dwell #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt;

  // Reload on state entry, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // The owning state leaves on the edge that ends its final counted cycle.
  assign done = (cnt == CW'(1));

endmodule

// File: rtl/simon_ctrl.sv
// Simon Says sequencer: grows a random pad pattern, plays it, checks presses. Option: SIMON_TIMEOUT_EN.
// Latency: start -> idx_en in 2 cycles; a press takes effect the cycle after it is sampled.
// Backpressure: none; start is ignored while busy and btn is ignored outside INPUT.
module simon_ctrl
  import simon_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 12000000,
  parameter int GAP_CYCLES     = 3000000,
  parameter int TIMEOUT_CYCLES = 60000000
) (
  input  logic  clk,
  input  logic  nrst,
  simon_if.slave bus
);

  // len counts 0..MAX_LEN; ptr only ever addresses stored entries.
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

`ifdef SIMON_TIMEOUT_EN
  localparam int MAXCYC = imax(imax(SHOW_CYCLES, GAP_CYCLES), TIMEOUT_CYCLES);
`else
  localparam int MAXCYC = imax(SHOW_CYCLES, GAP_CYCLES);
`endif
  localparam int CW = $clog2(MAXCYC) + 1;

  state_t        state, state_n;
  logic [LW-1:0] len, len_n;
  logic [PW-1:0] ptr, ptr_n;
  idx_t          mem [MAX_LEN];

  logic          mem_we;
  logic          dw_load;
  logic [CW-1:0] dw_val;
  logic          dw_done;

  idx_t          cur;
  logic          last;
  logic          press;
  logic          hit;

  assign cur   = mem[ptr];
  assign last  = (LW'(ptr) == LW'(len - 1'b1));
  assign press = (bus.btn != '0);
  // Multi-bit values never equal a one-hot pattern, so they fall into the miss path.
  assign hit   = (bus.btn == onehot(cur));

  simon_dwell #(
    .CW(CW)
  ) u_dwell (
    .clk      (clk),
    .nrst     (nrst),
    .load     (dw_load),
    .load_val (dw_val),
    .done     (dw_done)
  );

  // Game state, sequence length and play/check pointer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      len   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      len   <= len_n;
      ptr   <= ptr_n;
    end
  end

  // Pattern storage is left unreset; len bounds which entries are meaningful.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[len[PW-1:0]] <= bus.rnd;
    end
  end

  // Next-state, pointer/length updates and dwell counter loads.
  always_comb begin
    state_n = state;
    len_n   = len;
    ptr_n   = ptr;
    mem_we  = 1'b0;
    dw_load = 1'b0;
    dw_val  = '0;

    unique case (state)
      IDLE, WIN, LOSE: begin
        if (bus.start) begin
          state_n = ADD;
          len_n   = '0;
          ptr_n   = '0;
        end
      end

      ADD: begin
        mem_we  = 1'b1;
        len_n   = len + 1'b1;
        ptr_n   = '0;
        state_n = SHOW_ON;
        dw_load = 1'b1;
        dw_val  = CW'(SHOW_CYCLES);
      end

      SHOW_ON: begin
        if (dw_done) begin
          state_n = SHOW_OFF;
          dw_load = 1'b1;
          dw_val  = CW'(GAP_CYCLES);
        end
      end

      SHOW_OFF: begin
        if (dw_done) begin
          if (last) begin
            state_n = INPUT;
            ptr_n   = '0;
`ifdef SIMON_TIMEOUT_EN
            dw_load = 1'b1;
            dw_val  = CW'(TIMEOUT_CYCLES);
`endif
          end else begin
            state_n = SHOW_ON;
            ptr_n   = ptr + 1'b1;
            dw_load = 1'b1;
            dw_val  = CW'(SHOW_CYCLES);
          end
        end
      end

      INPUT: begin
        // A press in the expiring cycle is judged before the timeout applies.
        if (press) begin
          if (!hit) begin
            state_n = LOSE;
          end else if (last) begin
            state_n = (len == LW'(MAX_LEN)) ? WIN : ADD;
          end else begin
            ptr_n   = ptr + 1'b1;
`ifdef SIMON_TIMEOUT_EN
            dw_load = 1'b1;
            dw_val  = CW'(TIMEOUT_CYCLES);
`endif
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (dw_done) begin
          state_n = LOSE;
        end
`endif
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from registered state; blank index while not displaying.
  always_comb begin
    bus.idx_en  = (state == SHOW_ON);
    bus.idx_out = (state == SHOW_ON) ? cur : idx_t'(0);
    bus.level   = len;
    bus.busy    = !((state == IDLE) || (state == WIN) || (state == LOSE));
    bus.win     = (state == WIN);
    bus.lose    = (state == LOSE);
  end

endmodule

// File: tb/tb_simon_ctrl.sv
// Directed bench for simon_ctrl with MAX_LEN=2, SHOW_CYCLES=3, GAP_CYCLES=2, TIMEOUT_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Timeout scenarios run only when SIMON_TIMEOUT_EN is defined.
module tb_simon_ctrl;

  logic clk;
  logic nrst;
  int   checks;
  int   errs;

  simon_if #(.LW(2)) bus ();

  simon_ctrl #(
    .MAX_LEN        (2),
    .SHOW_CYCLES    (3),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_idx_en"},  32'(bus.idx_en),  0);
    chk({tag, "_idx_out"}, 32'(bus.idx_out), 0);
    chk({tag, "_level"},   32'(bus.level),   0);
    chk({tag, "_busy"},    32'(bus.busy),    0);
    chk({tag, "_win"},     32'(bus.win),     0);
    chk({tag, "_lose"},    32'(bus.lose),    0);
  endtask

  // Start a game; returns one cycle after ADD, i.e. in the first SHOW_ON cycle.
  task automatic begin_game(input string tag, input logic [3:0] r);
    bus.start = 1'b1;
    bus.rnd   = r;
    step();
    bus.start = 1'b0;
    chk({tag, "_add_busy"},  32'(bus.busy),   1);
    chk({tag, "_add_en"},    32'(bus.idx_en), 0);
    chk({tag, "_add_level"}, 32'(bus.level),  0);
    step();
    chk({tag, "_show_level"}, 32'(bus.level), 1);
  endtask

  // One displayed entry: 3 cycles on with the index, 2 cycles blank.
  task automatic show_entry(input string tag, input logic [3:0] e, input bit noise);
    for (int i = 0; i < 3; i++) begin
      if (noise) bus.btn = 16'h8001;
      chk({tag, "_on_en"},  32'(bus.idx_en),  1);
      chk({tag, "_on_idx"}, 32'(bus.idx_out), 32'(e));
      chk({tag, "_on_busy"}, 32'(bus.busy),   1);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      if (noise) bus.btn = 16'h0001;
      chk({tag, "_off_en"},  32'(bus.idx_en),  0);
      chk({tag, "_off_idx"}, 32'(bus.idx_out), 0);
      chk({tag, "_off_lose"}, 32'(bus.lose),   0);
      step();
    end
    bus.btn = '0;
  endtask

  task automatic press(input logic [15:0] v);
    bus.btn = v;
    step();
    bus.btn = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    errs      = 0;
    nrst      = 1'b0;
    bus.start = 1'b0;
    bus.rnd   = '0;
    bus.btn   = '0;
    step();
    step();
    chk_all_zero("reset");
    nrst = 1'b1;
    step();
    chk_all_zero("idle");

    // Round 1: single entry 5, with wrong-looking strobes during the display.
    begin_game("r1", 4'd5);
    show_entry("r1e0", 4'd5, 1'b1);
    chk("r1_input_busy", 32'(bus.busy), 1);
    chk("r1_input_lose", 32'(bus.lose), 0);
    bus.rnd = 4'd10;
    press(16'h0020);
    chk("r1_to_add_en",    32'(bus.idx_en), 0);
    chk("r1_to_add_level", 32'(bus.level),  1);
    chk("r1_to_add_busy",  32'(bus.busy),   1);
    step();
    chk("r2_level", 32'(bus.level), 2);
    show_entry("r2e0", 4'd5, 1'b0);
    show_entry("r2e1", 4'd10, 1'b0);

    // start during INPUT does nothing.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("ign_start_level", 32'(bus.level),  2);
    chk("ign_start_en",    32'(bus.idx_en), 0);
    chk("ign_start_busy",  32'(bus.busy),   1);
    press(16'h0020);
    chk("r2_p0_busy", 32'(bus.busy), 1);
    chk("r2_p0_win",  32'(bus.win),  0);
    press(16'h0400);
    chk("win_win",   32'(bus.win),    1);
    chk("win_busy",  32'(bus.busy),   0);
    chk("win_level", 32'(bus.level),  2);
    chk("win_en",    32'(bus.idx_en), 0);
    step();
    chk("win_hold", 32'(bus.win), 1);

    // Wrong single-bit press.
    begin_game("lose", 4'd3);
    show_entry("lose_e0", 4'd3, 1'b0);
    press(16'h0010);
    chk("lose_lose", 32'(bus.lose), 1);
    chk("lose_busy", 32'(bus.busy), 0);
    chk("lose_win",  32'(bus.win),  0);
    press(16'h0008);
    chk("lose_hold", 32'(bus.lose), 1);

    // Multi-bit press containing the right pad still loses.
    begin_game("multi", 4'd3);
    show_entry("multi_e0", 4'd3, 1'b0);
    press(16'h0009);
    chk("multi_lose", 32'(bus.lose), 1);
    chk("multi_busy", 32'(bus.busy), 0);

`ifdef SIMON_TIMEOUT_EN
    // No press: four INPUT cycles, then LOSE.
    begin_game("tmo", 4'd1);
    show_entry("tmo_e0", 4'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("tmo_wait_lose", 32'(bus.lose), 0);
      step();
    end
    chk("tmo_lose", 32'(bus.lose), 1);

    // Correct press in the fourth cycle beats the timeout.
    begin_game("tmo2", 4'd1);
    show_entry("tmo2_e0", 4'd1, 1'b0);
    step();
    step();
    step();
    bus.rnd = 4'd6;
    press(16'h0002);
    chk("tmo2_lose",  32'(bus.lose),  0);
    chk("tmo2_busy",  32'(bus.busy),  1);
    step();
    chk("tmo2_level", 32'(bus.level), 2);
    chk("tmo2_en",    32'(bus.idx_en), 1);
    chk("tmo2_idx",   32'(bus.idx_out), 1);
`endif

    // Asynchronous reset in the middle of SHOW_ON.
    begin_game("rst", 4'd7);
    chk("rst_pre_en", 32'(bus.idx_en), 1);
    #2;
    nrst = 1'b0;
    #1;
    chk_all_zero("rst_async");
    step();
    chk_all_zero("rst_held");
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_idle_busy", 32'(bus.busy),   0);
      chk("rst_idle_en",   32'(bus.idx_en), 0);
    end
    begin_game("post", 4'd9);
    show_entry("post_e0", 4'd9, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/simon_ctrl.md
# simon_ctrl

Game sequencer for the Simon Says project. Grows a random pattern of 4-bit pad indices by one entry per round, plays the pattern to the downstream one-hot pad/LED decoder through an index plus enable pair, then checks the player's button presses against it. Sits between the LFSR random source, the synchronized and edge-detected button strobes, and the display decoder.

## Interface
- MAX_LEN, 16: maximum sequence length; reaching it ends the game with a win. Legal range 1..32.
- SHOW_CYCLES, 12000000: cycles each entry is displayed. Must be ≥1.
- GAP_CYCLES, 3000000: blank cycles after each displayed entry. Must be ≥1.
- TIMEOUT_CYCLES, 60000000: input timeout in cycles. Used only under SIMON_TIMEOUT_EN.

- clk, in, 1: system clock. One clock domain.
- nrst, in, 1: reset, asynchronous, active-low.
- start, in, 1: level sampled each cycle. Honoured only in IDLE, WIN and LOSE.
- rnd, in, 4: random index from the LFSR, sampled in ADD.
- btn, in, 16: press strobes, each one cycle wide. Any nonzero value counts as one press.
- idx_out, out, 4: index to the decoder.
- idx_en, out, 1: decoder enable.
- level, out, $clog2(MAX_LEN+1): current sequence length.
- busy, out, 1: high in every state except IDLE, WIN and LOSE.
- win, out, 1: high in WIN.
- lose, out, 1: high in LOSE.

## Operation
- States: IDLE, ADD, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE.
- IDLE to ADD on start. Clear len and ptr on this transition.
- ADD lasts one cycle:
  - mem[len] <= rnd; len <= len+1; ptr <= 0; go to SHOW_ON.
- SHOW_ON:
  - idx_out = mem[ptr], idx_en = 1.
  - After SHOW_CYCLES cycles, go to SHOW_OFF.
- SHOW_OFF:
  - idx_en = 0.
  - After GAP_CYCLES cycles: if ptr == len-1, go to INPUT with ptr <= 0; otherwise ptr <= ptr+1 and return to SHOW_ON.
- INPUT, in a cycle where btn != 0:
  - Correct press: btn == (16'b1 << mem[ptr]).
  - Correct and ptr < len-1: ptr <= ptr+1.
  - Correct and ptr == len-1: go to WIN if len == MAX_LEN, otherwise go to ADD.
  - Any other nonzero btn, including multi-bit values: go to LOSE.
  - btn == 0: hold.
- WIN and LOSE: hold; idx_en = 0. On start, clear len and go to ADD. This is a new game.
- start in ADD, SHOW_ON, SHOW_OFF or INPUT is ignored.
- btn outside INPUT is ignored.
- Outputs are Moore: decoded from registered state, ptr, len and mem.
- idx_out = 0 whenever idx_en = 0.

## Timing
- Reset values:
  - State IDLE; len = 0, ptr = 0, all counters = 0.
  - idx_out = 0, idx_en = 0, level = 0, busy = 0, win = 0, lose = 0.
  - mem is not reset.
- Reset asserted mid-game returns to IDLE immediately. No partial round survives.
- Start handling: start high at edge t means the state is ADD at t+1 and SHOW_ON at t+2. idx_en rises 2 cycles after start is sampled.
- Display duty per entry: idx_en high exactly SHOW_CYCLES cycles, then low exactly GAP_CYCLES cycles.
- Press handling: a press sampled at edge t takes effect at t+1. A final correct press reaches ADD at t+1 and the next SHOW_ON at t+2.
- Dwell counter: one down-counter shared by SHOW_ON, SHOW_OFF and the timeout. Loaded on state entry; the state exits when the counter reaches 1.
- Counter width: $clog2 of the largest enabled *_CYCLES parameter, plus 1.

## Configuration
- SIMON_TIMEOUT_EN defined:
  - On entry to INPUT and after each correct press, load TIMEOUT_CYCLES.
  - If TIMEOUT_CYCLES cycles pass with btn == 0, go to LOSE.
  - A press in the expiring cycle takes priority over the timeout.
- Undefined: INPUT waits indefinitely, and the TIMEOUT_CYCLES logic is absent.

## Structure
- Package simon_pkg holds:
  - the state_t enum;
  - the 4-bit idx_t typedef;
  - the 16-bit pad_t typedef;
  - a function onehot(idx_t) returning pad_t.
- Sub-module simon_dwell: the loadable down-counter. Ports: load, load value, done.
- mem is a MAX_LEN × 4 register array inside simon_ctrl.

## Test plan
All scenarios use MAX_LEN=2, SHOW_CYCLES=3, GAP_CYCLES=2.
- Reset: nrst low mid-SHOW_ON.
  - All outputs 0 and state IDLE while nrst is low.
  - After release, start is required again.
- Round 1:
  - Stimulus: start with rnd=5.
  - Expected: idx_en high for 3 cycles with idx_out=5, then low for 2; level=1; busy=1.
  - Stimulus: btn=16'h0020.
  - Expected: ADD; round 2 shows index 5, then the new rnd.
- Win:
  - Stimulus: rnd=5, then 10; press 16'h0020, then 16'h0400.
  - Expected: win=1, busy=0, level=2. start then returns level to 1.
- Lose:
  - Stimulus: rnd=3; press 16'h0010.
  - Expected: lose=1 the next cycle. A multi-bit btn=16'h0009 for the same entry also gives lose=1.
- Ignored inputs:
  - btn strobes during SHOW_ON and SHOW_OFF, and start during INPUT, do not change state.
- Timeout, with SIMON_TIMEOUT_EN and TIMEOUT_CYCLES=4:
  - No press: lose=1 after 4 INPUT cycles.
  - Correct press in cycle 4: play continues.
